// File: rtl/sram64_bridge_pkg.sv
// Shared types and constants for the 64-bit SRAM initiator bridge.
package sram64_bridge_pkg;

    localparam int SRAM64_MAX_READ_LATENCY = 2;
    localparam int SRAM64_ADDR_LSB         = 3;

    typedef struct packed {
        logic [63:0] rdata;
        logic        write;
        logic        err;
    } resp_t;

    typedef struct packed {
        logic write;
        logic err;
    } tag_t;

endpackage

// File: rtl/sram64_resp_fifo.sv
// Circular response FIFO; DEPTH need not be a power of two, push and pop may share a cycle.
// dout shows the stored head and is meaningful only while !empty.
module sram64_resp_fifo
    import sram64_bridge_pkg::*;
#(
    parameter int  DEPTH = 3,
    parameter type T     = resp_t
) (
    input  logic                         clka,
    input  logic                         rst,
    input  logic                         push,
    input  T                             din,
    input  logic                         pop,
    output T                             dout,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T               mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty  = (count == '0);
    assign do_pop = pop && !empty;
    assign dout   = mem[rd_ptr];

    always_ff @(posedge clka) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            if (push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram64_master_bridge.sv
// Valid/ready to 64-bit SRAM-port initiator; response appears READ_LATENCY+1 cycles after accept.
// Credit counter holds req_ready low while RESP_DEPTH responses are owed; SRAM64_BRIDGE_ALIGN_CHECK_EN flags misaligned requests.
module sram64_master_bridge
    import sram64_bridge_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int RESP_DEPTH   = 3
) (
    input  logic        clka,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_write,
    output logic        resp_err,
    output logic [63:0] addra,
    output logic [63:0] dina,
    output logic [7:0]  wea,
    output logic        ena,
    input  logic [63:0] douta
);

    localparam int LAT = (READ_LATENCY > SRAM64_MAX_READ_LATENCY) ? SRAM64_MAX_READ_LATENCY : READ_LATENCY;
    localparam int OW  = $clog2(RESP_DEPTH + 1);

    logic                        accept;
    logic                        pop;
    logic                        req_err;
    logic                        fifo_empty;
    logic [OW-1:0]               occ;
    logic [OW-1:0]               unused_fifo_count;
    tag_t                        req_tag;
    tag_t                        exit_tag;
    logic [LAT-1:0]              pipe_vld;
    tag_t [LAT-1:0]              pipe_tag;
    resp_t                       cap;
    resp_t                       head;

`ifdef SRAM64_BRIDGE_ALIGN_CHECK_EN
    assign req_err = (req_addr[2:0] != 3'b000) && (req_wstrb != 8'hFF);
`else
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^req_addr[2:0];
    assign req_err         = 1'b0;
`endif

    assign req_ready = !rst && (occ < OW'(RESP_DEPTH));
    assign accept    = req_valid && req_ready;
    // Misaligned requests still consume a credit but never touch the SRAM.
    assign ena       = accept && !req_err;
    assign wea       = ena ? req_wstrb : 8'h00;
    assign addra     = {req_addr[63:SRAM64_ADDR_LSB], {SRAM64_ADDR_LSB{1'b0}}};
    assign dina      = req_wdata;
    assign req_tag   = '{write: (req_wstrb != 8'h00), err: req_err};

    generate
        if (LAT == 1) begin : g_lat1
            always_ff @(posedge clka) begin
                if (rst) begin
                    pipe_vld <= '0;
                    pipe_tag <= '0;
                end else begin
                    pipe_vld[0] <= accept;
                    pipe_tag[0] <= req_tag;
                end
            end
        end else begin : g_latn
            always_ff @(posedge clka) begin
                if (rst) begin
                    pipe_vld <= '0;
                    pipe_tag <= '0;
                end else begin
                    pipe_vld <= {pipe_vld[LAT-2:0], accept};
                    pipe_tag <= {pipe_tag[LAT-2:0], req_tag};
                end
            end
        end
    endgenerate

    assign exit_tag = pipe_tag[LAT-1];
    assign cap      = '{rdata: (exit_tag.write || exit_tag.err) ? 64'h0 : douta,
                        write: exit_tag.write,
                        err:   exit_tag.err};

    sram64_resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .T     (resp_t)
    ) u_resp_fifo (
        .clka  (clka),
        .rst   (rst),
        .push  (pipe_vld[LAT-1]),
        .din   (cap),
        .pop   (pop),
        .dout  (head),
        .empty (fifo_empty),
        .count (unused_fifo_count)
    );

    assign resp_valid = !fifo_empty;
    assign pop        = resp_valid && resp_ready;
    assign resp_rdata = fifo_empty ? 64'h0 : head.rdata;
    assign resp_write = !fifo_empty && head.write;
    assign resp_err   = !fifo_empty && head.err;

    // occ covers both pipe and FIFO, so a captured response always finds a free slot.
    always_ff @(posedge clka) begin
        if (rst) begin
            occ <= '0;
        end else if (accept && !pop) begin
            occ <= occ + 1'b1;
        end else if (!accept && pop) begin
            occ <= occ - 1'b1;
        end
    end

endmodule

// File: tb/tb_sram64_master_bridge.sv
// Directed bench for sram64_master_bridge with a queue-based response model and SRAM responder.
module tb_sram64_master_bridge;

    localparam int LAT   = 1;
    localparam int DEPTH = 3;
`ifdef SRAM64_BRIDGE_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clka = 1'b0;
    logic        rst  = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_addr  = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wstrb = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_rdata;
    logic        resp_write;
    logic        resp_err;
    logic [63:0] addra;
    logic [63:0] dina;
    logic [7:0]  wea;
    logic        ena;
    logic [63:0] douta = '0;

    always #5 clka = ~clka;

    sram64_master_bridge #(.READ_LATENCY(LAT), .RESP_DEPTH(DEPTH)) dut (
        .clka(clka), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_write(resp_write), .resp_err(resp_err),
        .addra(addra), .dina(dina), .wea(wea), .ena(ena), .douta(douta)
    );

    // SRAM responder: unwritten words read back as their own byte address.
    logic [63:0] sram [logic [60:0]];
    logic [63:0] sram_w;
    always @(posedge clka) begin
        if (ena) begin
            sram_w = sram.exists(addra[63:3]) ? sram[addra[63:3]] : addra;
            for (int b = 0; b < 8; b++)
                if (wea[b]) sram_w[8*b +: 8] = dina[8*b +: 8];
            sram[addra[63:3]] = sram_w;
            douta <= sram_w;
        end
    end

    typedef struct { logic [63:0] rdata; logic write; logic err; int due; } exp_t;
    typedef struct { logic [63:0] rdata; logic write; logic err; int cyc; } log_t;

    exp_t        exp_q [$];
    log_t        rsp_log [$];
    int          acc_cyc [$];
    logic [63:0] ref_mem [logic [60:0]];
    int cyc = 0, n_vec = 0, n_err = 0, n_acc = 0, n_ena = 0, n_wea = 0, n_wea_hit = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_log(input int k, input logic [63:0] rd, input logic wr, input logic er);
        if (k < rsp_log.size()) begin
            check($sformatf("log%0d_rdata", k), rsp_log[k].rdata, rd);
            check($sformatf("log%0d_write", k), {63'b0, rsp_log[k].write}, {63'b0, wr});
            check($sformatf("log%0d_err", k), {63'b0, rsp_log[k].err}, {63'b0, er});
        end else begin
            check($sformatf("log%0d_present", k), 64'd0, 64'd1);
        end
    endtask

    // Model: every accepted request owes one response, visible LAT+1 cycles later, in order.
    always @(negedge clka) begin
        bit          m_ready, m_valid, m_err, m_acc, m_ena;
        exp_t        e;
        logic [60:0] k;
        cyc++;
        if (rst) begin
            check("ready_in_rst", {63'b0, req_ready}, 64'd0);
            check("ena_in_rst", {63'b0, ena}, 64'd0);
            exp_q.delete();
        end else begin
            m_ready = exp_q.size() < DEPTH;
            m_err   = ALIGN && (req_addr[2:0] != 3'b000) && (req_wstrb != 8'hFF);
            m_acc   = req_valid && m_ready;
            m_ena   = m_acc && !m_err;
            m_valid = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
            check("req_ready", {63'b0, req_ready}, {63'b0, m_ready});
            check("ena", {63'b0, ena}, {63'b0, m_ena});
            check("wea", {56'b0, wea}, m_ena ? {56'b0, req_wstrb} : 64'd0);
            check("addra", addra, req_addr & ~64'h7);
            check("dina", dina, req_wdata);
            check("resp_valid", {63'b0, resp_valid}, {63'b0, m_valid});
            if (m_valid) begin
                check("resp_rdata", resp_rdata, exp_q[0].rdata);
                check("resp_write", {63'b0, resp_write}, {63'b0, exp_q[0].write});
                check("resp_err", {63'b0, resp_err}, {63'b0, exp_q[0].err});
            end
            if (req_valid && req_ready) begin
                n_acc++;
                acc_cyc.push_back(cyc);
            end
            if (ena) n_ena++;
            if (wea != 8'h00) n_wea++;
            if (ena && wea == 8'h0F) n_wea_hit++;
            if (resp_valid && resp_ready)
                rsp_log.push_back('{rdata: resp_rdata, write: resp_write, err: resp_err, cyc: cyc});
            if (m_valid && resp_ready) void'(exp_q.pop_front());
            if (m_acc) begin
                k       = req_addr[63:3];
                e.due   = cyc + LAT + 1;
                e.write = (req_wstrb != 8'h00);
                e.err   = m_err;
                e.rdata = 64'h0;
                if (!m_err) begin
                    if (!ref_mem.exists(k)) ref_mem[k] = {k, 3'b000};
                    if (e.write) begin
                        for (int b = 0; b < 8; b++)
                            if (req_wstrb[b]) ref_mem[k][8*b +: 8] = req_wdata[8*b +: 8];
                    end else begin
                        e.rdata = ref_mem[k];
                    end
                end
                exp_q.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic send(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        int budget;
        budget    = 0;
        req_valid = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
        @(negedge clka);
        while (!req_ready && budget < 50) begin
            @(negedge clka);
            budget++;
        end
        check("send_accepted", {63'b0, req_ready}, 64'd1);
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clka);
        check("rst_req_ready", {63'b0, req_ready}, 64'd1);
        check("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        check("rst_resp_write", {63'b0, resp_write}, 64'd0);
        check("rst_resp_err", {63'b0, resp_err}, 64'd0);
        check("rst_wea", {56'b0, wea}, 64'd0);
        tick();

        // Write the LED word, read it back.
        resp_ready = 1'b1;
        rsp_log.delete();
        send(64'h6400_0000, 64'h0000_ABCD_1234_5678, 8'hFF);
        send(64'h6400_0000, 64'h0, 8'h00);
        repeat (6) tick();
        check("led_count", rsp_log.size(), 64'd2);
        check_log(0, 64'h0, 1'b1, 1'b0);
        check_log(1, 64'h0000_ABCD_1234_5678, 1'b0, 1'b0);

        // Streaming reads.
        rsp_log.delete();
        acc_cyc.delete();
        for (int i = 0; i < 8; i++) send(64'h6400_0010, 64'h0, 8'h00);
        repeat (6) tick();
        check("stream_count", rsp_log.size(), 64'd8);
        check("stream_accept_span", acc_cyc[7] - acc_cyc[0], 64'd7);
        check("stream_first_latency", rsp_log[0].cyc - acc_cyc[0], 64'd2);
        check("stream_resp_span", rsp_log[7].cyc - rsp_log[0].cyc, 64'd7);
        for (int i = 0; i < 8; i++) check_log(i, 64'h6400_0010, 1'b0, 1'b0);

        // Back-pressure.
        resp_ready = 1'b0;
        rsp_log.delete();
        n_acc = 0;
        fork
            begin
                for (int i = 0; i < 5; i++) send(64'h6400_0020 + 64'(8 * i), 64'h0, 8'h00);
            end
            begin
                repeat (8) tick();
                check("bp_accepted", n_acc, 64'd3);
                check("bp_ready_low", {63'b0, req_ready}, 64'd0);
                resp_ready = 1'b1;
            end
        join
        repeat (8) tick();
        check("bp_total_accepted", n_acc, 64'd5);
        check("bp_count", rsp_log.size(), 64'd5);
        for (int i = 0; i < 5; i++) check_log(i, 64'h6400_0020 + 64'(8 * i), 1'b0, 1'b0);

        // Byte strobes.
        rsp_log.delete();
        n_wea = 0;
        n_wea_hit = 0;
        send(64'h6400_0008, 64'hFFFF_FFFF_0000_0012, 8'h0F);
        send(64'h6400_0008, 64'h0, 8'h00);
        repeat (5) tick();
        check("strb_wea_cycles", n_wea, 64'd1);
        check("strb_wea_hit", n_wea_hit, 64'd1);
        check("strb_count", rsp_log.size(), 64'd2);
        check_log(1, 64'h0000_0000_0000_0012, 1'b0, 1'b0);

        // Reset with two reads outstanding.
        resp_ready = 1'b0;
        rsp_log.delete();
        send(64'h6400_0030, 64'h0, 8'h00);
        send(64'h6400_0038, 64'h0, 8'h00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clka);
        check("mid_rst_ready", {63'b0, req_ready}, 64'd1);
        check("mid_rst_valid", {63'b0, resp_valid}, 64'd0);
        tick();
        resp_ready = 1'b1;
        repeat (6) tick();
        check("mid_rst_no_resp", rsp_log.size(), 64'd0);

`ifdef SRAM64_BRIDGE_ALIGN_CHECK_EN
        // Misaligned read errors out without touching the SRAM.
        rsp_log.delete();
        n_ena = 0;
        send(64'h6400_0003, 64'h0, 8'h00);
        send(64'h6400_0018, 64'h0, 8'h00);
        repeat (5) tick();
        check("align_ena_count", n_ena, 64'd1);
        check("align_count", rsp_log.size(), 64'd2);
        check_log(0, 64'h0, 1'b0, 1'b1);
        check_log(1, 64'h6400_0018, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram64_master_bridge.md
# sram64_master_bridge

Initiator-side bridge driving a 64-bit SRAM-style port (`addra/dina/douta/ena/wea`, fixed read latency) from a valid/ready request channel, and returning in-order responses on a valid/ready response channel. It sits between a core/LSU and board I/O or BRAM responders, such as the `0x64000000` board I/O window. Reads and writes are pipelined, with credit-based back-pressure so no response is ever dropped.

## Interface
- `READ_LATENCY`, 1: cycles from the `ena` sample edge until `douta` is valid. Legal values are 1 and 2.
- `RESP_DEPTH`, 3: response FIFO entries. Full throughput requires `RESP_DEPTH >= READ_LATENCY+2`.
- `clka` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted this cycle when `req_valid && req_ready`.
- `req_addr` in 64: byte address.
- `req_wdata` in 64: write data.
- `req_wstrb` in 8: byte write enables. 0 means read.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: response consumed this cycle.
- `resp_rdata` out 64: read data. 0 for write responses.
- `resp_write` out 1: response belongs to a write.
- `resp_err` out 1: misaligned request (only with the macro; otherwise tied 0).
- `addra` out 64: SRAM address, always `{req_addr[63:3],3'b0}`.
- `dina` out 64: equals `req_wdata`.
- `wea` out 8: `req_wstrb` when issuing, else 0.
- `ena` out 1: issue strobe.
- `douta` in 64: SRAM read data.

## Operation
- Occupancy counter `occ` (0..`RESP_DEPTH`) counts requests in flight plus FIFO entries.
- `req_ready = !rst && occ < RESP_DEPTH`.
- Accept: `ena = req_valid && req_ready`. `addra`, `dina` and `wea` are combinational pass-through in the same cycle.
- Each accept pushes a tag `{write, err}` into a `READ_LATENCY`-stage valid shift pipe.
- When a tag exits the pipe, `{douta (or 0 for writes/errors), write, err}` is written into the FIFO.
- Pop on `resp_valid && resp_ready`.
- `occ` arithmetic: `+1` on accept, `-1` on pop, unchanged when both occur in the same cycle. Overflow cannot occur by construction.
- Responses are strictly in request order; writes produce an acknowledgement response.
- The FIFO can never be full at capture time, because the credit rule guarantees a free entry.
- `resp_*` outputs are driven from the FIFO head. The head is stable while `resp_valid && !resp_ready`.
- Read-after-write to the same address is issued back-to-back. Ordering hazards belong to the responder; the bridge does not stall.

## Timing
- Reset values: `req_ready=0`, `ena=0`, `wea=0`, `resp_valid=0`, `resp_rdata=0`, `resp_write=0`, `resp_err=0`, `occ=0`, pipe and FIFO empty.
- Accept in cycle c0 → `douta` captured at the end of cycle c(`READ_LATENCY`) → `resp_valid` in c(`READ_LATENCY`+1).
- Throughput: one request per cycle sustained with `resp_ready=1` and default parameters.
- Back-pressure: `resp_ready=0` fills the FIFO; `req_ready` drops once `occ==RESP_DEPTH`. The cycle after the first pop, `req_ready` rises again.
- Simultaneous accept and pop at `occ==RESP_DEPTH` is impossible, since `req_ready=0`.
- Simultaneous accept and pop at `occ==RESP_DEPTH-1`: both occur, and `occ` is unchanged.
- Reset mid-operation: in-flight tags and FIFO contents are discarded, and `ena` is 0 during `rst`. Data the responder returns for discarded requests is ignored. No response is emitted for them.
- FIFO pointers wrap modulo `RESP_DEPTH`, which need not be a power of 2.

## Configuration
- `SRAM64_BRIDGE_ALIGN_CHECK_EN` defined:
  - A request with `req_addr[2:0]!=0` and `req_wstrb` not equal to 0xFF is still accepted.
  - For such a request, `ena` and `wea` stay 0.
  - An error tag travels the same pipe, and the response has `resp_err=1`, `resp_rdata=0`, with order preserved.
- `SRAM64_BRIDGE_ALIGN_CHECK_EN` not defined:
  - `req_addr[2:0]` is ignored.
  - Every accept asserts `ena`.
  - `resp_err` is constant 0.

## Structure
- Package `sram64_bridge_pkg`:
  - `resp_t` struct `{rdata[63:0], write, err}`.
  - `tag_t` struct `{write, err}`.
  - Constants `SRAM64_MAX_READ_LATENCY=2` and `SRAM64_ADDR_LSB=3`.
- Sub-module `sram64_resp_fifo`, parameterised by `DEPTH` and `resp_t`:
  - Synchronous reset.
  - Push/pop in the same cycle allowed.
  - Exposes `empty` and `count`.
- The top level holds the credit counter, the tag pipe, and the `READ_LATENCY` generate.

## Test plan
- Write LED then read it back: write `addr=0x64000000`, `wdata=0x0000_ABCD_1234_5678`, `wstrb=0xFF`; then read the same address → write response (`resp_write=1`, `rdata=0`), then read response with `rdata=0x0000_ABCD_1234_5678`.
- Streaming reads: 8 back-to-back reads of `0x64000010` with a model returning the address-indexed word, `resp_ready=1` → 8 responses in order, one per cycle, first at c2 (`READ_LATENCY=1`).
- Back-pressure: `resp_ready=0` while 5 reads are offered → exactly `RESP_DEPTH`=3 accepted, `req_ready=0` afterward. Then `resp_ready=1` → responses in order, remaining 2 accepted, no loss or duplication.
- Byte strobes: `wstrb=0x0F`, `wdata=0xFFFF_FFFF_0000_0012` → `wea=0x0F` for exactly one cycle together with `ena=1`; `wea=0` otherwise.
- Reset mid-stream: assert `rst` for 1 cycle with 2 reads in flight → no responses emitted, `occ=0`, `req_ready=1` the first cycle after `rst` deasserts.
- Macro defined: read at `0x64000003` → `ena` never asserted, response `resp_err=1`, `rdata=0`. A following aligned read returns normally, in order.
